// File: rtl/rect_fill_engine.sv
// Filled-rectangle rasterizer feeding the frame-buffer GPU write port.
// Accepts one corner-pair command and emits one registered pixel write per cycle.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | waiting for a command; cmd_ready high outside reset
// SETUP | clamp far corner to screen, reject empty, seed first pixel
// FILL  | one pixel write per cycle in raster order
// DONE  | one-cycle completion pulse, then back to IDLE
module rect_fill_engine #(
    parameter int H_RES   = 320,
    parameter int V_RES   = 240,
    parameter int ADDR_W  = 17,
    parameter int COLOR_W = 4
) (
    input  logic               gpu_clk,
    input  logic               gpu_rst,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [8:0]         cmd_x0,
    input  logic [7:0]         cmd_y0,
    input  logic [8:0]         cmd_x1,
    input  logic [7:0]         cmd_y1,
    input  logic [COLOR_W-1:0] cmd_color,
    output logic [ADDR_W-1:0]  gpu_pixel_addr,
    output logic [COLOR_W-1:0] gpu_pixel_data,
    output logic               gpu_we,
    output logic               busy,
    output logic               done
);

    typedef enum logic [1:0] {IDLE, SETUP, FILL, DONE} state_t;

    localparam logic [9:0]        X_LIM      = 10'(H_RES);
    localparam logic [9:0]        X_LAST     = 10'(H_RES - 1);
    localparam logic [8:0]        Y_LIM      = 9'(V_RES);
    localparam logic [8:0]        Y_LAST     = 9'(V_RES - 1);
    localparam logic [ADDR_W-1:0] ROW_STRIDE = ADDR_W'(H_RES);

    state_t               state, state_d;
    logic [8:0]           xmin, xmin_d, xmax, xmax_d, x, x_d;
    logic [7:0]           ymin, ymin_d, ymax, ymax_d, y, y_d;
    logic [COLOR_W-1:0]   color, color_d;
    logic [ADDR_W-1:0]    row_base, row_base_d;
    logic [ADDR_W-1:0]    addr_d;
    logic [COLOR_W-1:0]   data_d;
    logic                 we_d, busy_d, done_d;
    logic                 empty;
    logic [ADDR_W-1:0]    setup_base;

    assign cmd_ready = (state == IDLE) & ~gpu_rst;

    // Only xmin/ymin can be off-screen after normalization; the far corner is clamped.
    assign empty      = ({1'b0, xmin} >= X_LIM) || ({1'b0, ymin} >= Y_LIM);
    assign setup_base = ADDR_W'(ymin) * ROW_STRIDE;

    always_ff @(posedge gpu_clk) begin
        if (gpu_rst) begin
            state          <= IDLE;
            gpu_we         <= 1'b0;
            gpu_pixel_addr <= '0;
            gpu_pixel_data <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            xmin           <= '0;
            xmax           <= '0;
            ymin           <= '0;
            ymax           <= '0;
            x              <= '0;
            y              <= '0;
            color          <= '0;
            row_base       <= '0;
        end else begin
            state          <= state_d;
            gpu_we         <= we_d;
            gpu_pixel_addr <= addr_d;
            gpu_pixel_data <= data_d;
            busy           <= busy_d;
            done           <= done_d;
            xmin           <= xmin_d;
            xmax           <= xmax_d;
            ymin           <= ymin_d;
            ymax           <= ymax_d;
            x              <= x_d;
            y              <= y_d;
            color          <= color_d;
            row_base       <= row_base_d;
        end
    end

    always_comb begin
        state_d    = state;
        xmin_d     = xmin;
        xmax_d     = xmax;
        ymin_d     = ymin;
        ymax_d     = ymax;
        x_d        = x;
        y_d        = y;
        color_d    = color;
        row_base_d = row_base;
        addr_d     = gpu_pixel_addr;
        data_d     = gpu_pixel_data;
        we_d       = 1'b0;
        busy_d     = busy;
        done_d     = 1'b0;

        case (state)
            IDLE: begin
                if (cmd_valid) begin
                    xmin_d  = (cmd_x0 < cmd_x1) ? cmd_x0 : cmd_x1;
                    xmax_d  = (cmd_x0 < cmd_x1) ? cmd_x1 : cmd_x0;
                    ymin_d  = (cmd_y0 < cmd_y1) ? cmd_y0 : cmd_y1;
                    ymax_d  = (cmd_y0 < cmd_y1) ? cmd_y1 : cmd_y0;
                    color_d = cmd_color;
                    busy_d  = 1'b1;
                    state_d = SETUP;
                end
            end
            SETUP: begin
                xmax_d = ({1'b0, xmax} > X_LAST) ? X_LAST[8:0] : xmax;
                ymax_d = ({1'b0, ymax} > Y_LAST) ? Y_LAST[7:0] : ymax;
                if (empty) begin
                    done_d  = 1'b1;
                    state_d = DONE;
                end else begin
                    // First pixel address is issued here so writes start the next cycle.
                    row_base_d = setup_base;
                    x_d        = xmin;
                    y_d        = ymin;
                    we_d       = 1'b1;
                    addr_d     = setup_base + ADDR_W'(xmin);
                    data_d     = color;
                    state_d    = FILL;
                end
            end
            FILL: begin
                if (x == xmax) begin
                    if (y == ymax) begin
                        done_d  = 1'b1;
                        state_d = DONE;
                    end else begin
                        x_d        = xmin;
                        y_d        = y + 8'd1;
                        row_base_d = row_base + ROW_STRIDE;
                        we_d       = 1'b1;
                        addr_d     = row_base + ROW_STRIDE + ADDR_W'(xmin);
                    end
                end else begin
                    x_d    = x + 9'd1;
                    we_d   = 1'b1;
                    addr_d = row_base + ADDR_W'(x) + ADDR_W'(1);
                end
            end
            DONE: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_rect_fill_engine.sv
// Directed bench for rect_fill_engine: hand-computed write sequences, latencies,
// clamping, empty commands and reset during a fill.
`timescale 1ns/1ps
module tb_rect_fill_engine;

    logic        gpu_clk = 1'b0;
    logic        gpu_rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [8:0]  cmd_x0 = '0, cmd_x1 = '0;
    logic [7:0]  cmd_y0 = '0, cmd_y1 = '0;
    logic [3:0]  cmd_color = '0;
    logic [16:0] gpu_pixel_addr;
    logic [3:0]  gpu_pixel_data;
    logic        gpu_we, busy, done;

    int n_checks = 0;
    int n_fail   = 0;

    rect_fill_engine dut (
        .gpu_clk        (gpu_clk),
        .gpu_rst        (gpu_rst),
        .cmd_valid      (cmd_valid),
        .cmd_ready      (cmd_ready),
        .cmd_x0         (cmd_x0),
        .cmd_y0         (cmd_y0),
        .cmd_x1         (cmd_x1),
        .cmd_y1         (cmd_y1),
        .cmd_color      (cmd_color),
        .gpu_pixel_addr (gpu_pixel_addr),
        .gpu_pixel_data (gpu_pixel_data),
        .gpu_we         (gpu_we),
        .busy           (busy),
        .done           (done)
    );

    always #5 gpu_clk = ~gpu_clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge gpu_clk);
        #1;
    endtask

    // Present a command in cycle T; returns in cycle T+1 with cmd_valid low.
    task automatic send(input logic [8:0] x0, input logic [7:0] y0,
                        input logic [8:0] x1, input logic [7:0] y1, input logic [3:0] c);
        int n = 0;
        while (!cmd_ready && n < 50) begin
            step();
            n++;
        end
        check("ready_before_send", 32'(n < 50), 1);
        cmd_x0 = x0; cmd_y0 = y0; cmd_x1 = x1; cmd_y1 = y1; cmd_color = c;
        cmd_valid = 1'b1;
        step();
        cmd_valid = 1'b0;
    endtask

    initial begin
        int exp2 [6] = '{328, 329, 330, 648, 649, 650};
        int exp3 [4] = '{76478, 76479, 76798, 76799};
        int bad;
        int n;
        int writes;
        int dones;
        int waddr [4];

        // Reset state
        step();
        check("rst_ready", cmd_ready, 0);
        check("rst_we", gpu_we, 0);
        check("rst_addr", gpu_pixel_addr, 0);
        check("rst_data", gpu_pixel_data, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        step();
        gpu_rst = 1'b0;
        step();
        check("ready_after_rst", cmd_ready, 1);

        // Single pixel (5,3), colour A
        send(9'd5, 8'd3, 9'd5, 8'd3, 4'hA);
        check("px_t1_busy", busy, 1);
        check("px_t1_we", gpu_we, 0);
        check("px_t1_ready", cmd_ready, 0);
        step();
        check("px_t2_we", gpu_we, 1);
        check("px_t2_addr", gpu_pixel_addr, 965);
        check("px_t2_data", gpu_pixel_data, 4'hA);
        step();
        check("px_t3_we", gpu_we, 0);
        check("px_t3_done", done, 1);
        check("px_t3_ready", cmd_ready, 0);
        step();
        check("px_t4_ready", cmd_ready, 1);
        check("px_t4_done", done, 0);
        check("px_t4_busy", busy, 0);

        // Swapped corners; colour input changes mid-fill must not leak through
        send(9'd10, 8'd2, 9'd8, 8'd1, 4'h3);
        cmd_color = 4'h9;
        step();
        for (int i = 0; i < 6; i++) begin
            check("swap_we", gpu_we, 1);
            check("swap_addr", gpu_pixel_addr, exp2[i]);
            check("swap_data", gpu_pixel_data, 4'h3);
            step();
        end
        check("swap_done", done, 1);
        check("swap_done_we", gpu_we, 0);
        step();

        // Clamp at bottom-right corner
        send(9'd318, 8'd238, 9'd511, 8'd255, 4'hF);
        step();
        for (int i = 0; i < 4; i++) begin
            check("clamp_we", gpu_we, 1);
            check("clamp_addr", gpu_pixel_addr, exp3[i]);
            step();
        end
        check("clamp_done", done, 1);
        check("clamp_end_we", gpu_we, 0);
        step();

        // Full-screen clear
        send(9'd0, 8'd0, 9'd319, 8'd239, 4'h0);
        check("clr_t1_we", gpu_we, 0);
        step();
        bad = 0;
        for (int i = 0; i < 76800; i++) begin
            if (gpu_we !== 1'b1 || gpu_pixel_addr !== 17'(i) || done !== 1'b0) bad++;
            step();
        end
        check("clr_seq_errors", bad, 0);
        check("clr_done", done, 1);
        check("clr_end_we", gpu_we, 0);
        step();
        check("clr_ready", cmd_ready, 1);

        // Off-screen: no writes, done at T+2
        send(9'd320, 8'd0, 9'd330, 8'd5, 4'h7);
        check("off_t1_busy", busy, 1);
        check("off_t1_we", gpu_we, 0);
        step();
        check("off_t2_done", done, 1);
        check("off_t2_busy", busy, 1);
        check("off_t2_we", gpu_we, 0);
        step();
        check("off_t3_done", done, 0);
        check("off_t3_busy", busy, 0);
        check("off_t3_ready", cmd_ready, 1);

        // Reset at the 10th write of a 20x20 fill
        send(9'd0, 8'd0, 9'd19, 8'd19, 4'h5);
        for (int i = 0; i < 10; i++) step();
        check("rmid_10th_we", gpu_we, 1);
        check("rmid_10th_addr", gpu_pixel_addr, 9);
        gpu_rst = 1'b1;
        cmd_x0 = 9'd2; cmd_y0 = 8'd2; cmd_x1 = 9'd3; cmd_y1 = 8'd2; cmd_color = 4'h7;
        cmd_valid = 1'b1;
        #1;
        check("rmid_ready_in_rst", cmd_ready, 0);
        step();
        gpu_rst = 1'b0;
        #1;
        check("rmid_after_we", gpu_we, 0);
        check("rmid_after_done", done, 0);
        check("rmid_after_busy", busy, 0);
        check("rmid_after_ready", cmd_ready, 1);
        step();
        check("hold_accept_busy", busy, 1);
        check("hold_accept_ready", cmd_ready, 0);
        n = 0; writes = 0; dones = 0;
        while (!cmd_ready && n < 20) begin
            if (gpu_we) begin
                if (writes < 4) waddr[writes] = int'(gpu_pixel_addr);
                writes++;
            end
            if (done) dones++;
            step();
            n++;
        end
        cmd_valid = 1'b0;
        check("hold_cycles", n, 4);
        check("hold_writes", writes, 2);
        check("hold_dones", dones, 1);
        check("hold_addr0", waddr[0], 642);
        check("hold_addr1", waddr[1], 643);
        step();
        check("hold_no_reaccept", busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
